// File: rtl/timer_display_seq.sv
// MM:SS BCD countdown timer that streams its value as a 5-character ASCII frame over valid/ready.
// Optional colon blink is enabled by defining TIMER_COLON_BLINK_EN.
module timer_display_seq #(
  parameter logic [15:0] RESET_TIME = 16'h0500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic        start,
  input  logic        pause,
  input  logic        tick_1hz,
  output logic [3:0]  bcd,
  input  logic [7:0]  ascii,
  output logic [7:0]  char_out,
  output logic [2:0]  char_idx,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        expired
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  logic        colon_q, colon_d;
  logic        dirty_q, dirty_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] frame_q;
  logic        frame_colon_q;
  logic        take;
  logic        changed;
  logic        tick_ok;
  logic [15:0] time_dec;
  logic [3:0]  digit;

  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    logic [15:0] r;
    r[15:12] = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
    r[11:8]  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
    r[7:4]   = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
    r[3:0]   = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
    return r;
  endfunction

  // Only ever applied to a nonzero value, so the minutes-tens digit cannot underflow.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Timer control: load > pause > start > tick.
  always_comb begin
    time_dec  = dec_bcd(time_q);
    tick_ok   = tick_1hz && running_q && (time_q != 16'h0000);
    time_d    = time_q;
    running_d = running_q;
    expired_d = expired_q;
    colon_d   = colon_q;
    changed   = 1'b0;
    if (load) begin
      time_d    = clamp_bcd(load_bcd);
      running_d = 1'b0;
      expired_d = 1'b0;
      colon_d   = 1'b1;
      changed   = 1'b1;
    end else if (pause) begin
      running_d = 1'b0;
    end else begin
      if (start && (time_q != 16'h0000)) begin
        running_d = 1'b1;
      end
      if (tick_ok) begin
        time_d  = time_dec;
        changed = 1'b1;
`ifdef TIMER_COLON_BLINK_EN
        colon_d = (time_dec == 16'h0000) ? 1'b1 : ~colon_q;
`endif
        if (time_dec == 16'h0000) begin
          expired_d = 1'b1;
          running_d = 1'b0;
        end
      end
    end
  end

  // Frame sequencer next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          take    = 1'b1;
          state_d = SEND;
          idx_d   = 3'd0;
        end
      end
      SEND: begin
        if (char_ready) begin
          if (idx_q == 3'd4) begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
    // A change in the same cycle as the snapshot must still produce a later frame.
    dirty_d = changed || (dirty_q && !take);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= 3'd0;
      time_q        <= RESET_TIME;
      running_q     <= 1'b0;
      expired_q     <= 1'b0;
      colon_q       <= 1'b1;
      dirty_q       <= 1'b1;
      frame_q       <= RESET_TIME;
      frame_colon_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      time_q    <= time_d;
      running_q <= running_d;
      expired_q <= expired_d;
      colon_q   <= colon_d;
      dirty_q   <= dirty_d;
      if (take) begin
        frame_q       <= time_q;
        frame_colon_q <= colon_q;
      end
    end
  end

  // Outputs are decoded from registered state so reset clears them at once.
  always_comb begin
    digit = 4'd0;
    case (idx_q)
      3'd0:    digit = frame_q[15:12];
      3'd1:    digit = frame_q[11:8];
      3'd3:    digit = frame_q[7:4];
      3'd4:    digit = frame_q[3:0];
      default: digit = 4'd0;
    endcase
    char_valid = (state_q == SEND);
    char_idx   = idx_q;
    bcd        = char_valid ? digit : 4'd0;
    char_out   = 8'h00;
    if (char_valid) begin
      if (idx_q == 3'd2) begin
        char_out = frame_colon_q ? 8'h3A : 8'h20;
      end else begin
        char_out = ascii;
      end
    end
    time_bcd = time_q;
    running  = running_q;
    expired  = expired_q;
  end

endmodule

// File: doc/timer_display_seq.md
TIMER_DISPLAY_SEQ -- requirements
Module: timer_display_seq

Interface
REQ-001 Parameter: RESET_TIME, 16'h0500, BCD {min tens, min ones, sec tens, sec ones} loaded at reset (05:00).
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: load  input  1  one-cycle pulse; loads load_bcd into the timer.
REQ-005 Port: load_bcd  input  16  BCD time {MT,MO,ST,SO} for load.
REQ-006 Port: start  input  1  pulse; begins countdown.
REQ-007 Port: pause  input  1  pulse; halts countdown.
REQ-008 Port: tick_1hz  input  1  one-cycle pulse per second.
REQ-009 Port: bcd  output  4  digit presented to the shared combinational BCD-to-ASCII converter.
REQ-010 Port: ascii  input  8  converter result for bcd, same cycle.
REQ-011 Port: char_out  output  8  ASCII character to display writer.
REQ-012 Port: char_idx  output  3  character position 0..4 within frame.
REQ-013 Port: char_valid  output  1  char_out/char_idx valid.
REQ-014 Port: char_ready  input  1  display writer accepts character.
REQ-015 Port: time_bcd  output  16  current timer value {MT,MO,ST,SO}.
REQ-016 Port: running  output  1  countdown active.
REQ-017 Port: expired  output  1  timer reached 00:00 while running; sticky until load or reset.

Function
REQ-018 Countdown: on tick_1hz with running=1 and time nonzero, time_bcd decrements by one second on the next edge.
REQ-019 Borrow chain: SO 0->9 borrows ST; ST 0->5 borrows MO; MO 0->9 borrows MT; MT decrements; 10:00 -> 09:59, 01:00 -> 00:59.
REQ-020 Decrement to 0000: same edge sets expired=1, running=0; further ticks ignored.
REQ-021 Load: time_bcd <= load_bcd with digits >9 clamped to 9 and ST >5 clamped to 5; running=0, expired=0.
REQ-022 start sets running=1 unless time_bcd=0000 (ignored); pause clears running.
REQ-023 Priority same cycle: load > pause > start > tick; a tick coincident with load, or with pause, is dropped.
REQ-024 Any change to time_bcd (load, decrement) or to the displayed colon sets an internal dirty flag.
REQ-025 Sequencer states: IDLE, SEND. IDLE with dirty=1: snapshot time_bcd into frame register, clear dirty, enter SEND with char_idx=0, char_valid=1 on the next cycle.
REQ-026 Frame order: idx0=MT, idx1=MO, idx2=8'h3A (':'), idx3=ST, idx4=SO; bcd drives snapshot digit for idx 0,1,3,4 (0 for idx 2); char_out=ascii for digit indices.
REQ-027 Handshake: char_valid, char_out, char_idx held stable until char_valid&char_ready; index advances on handshake; handshake at idx4 returns to IDLE with char_valid=0 next cycle.
REQ-028 Timer changes during SEND do not alter the in-flight frame; dirty is set and a new frame starts the cycle after returning to IDLE.
REQ-029 Frame cost with char_ready tied high: 1 cycle IDLE-to-SEND plus 5 transfer cycles.

Reset
REQ-030 rst asynchronously forces: time_bcd=RESET_TIME, running=0, expired=0, state=IDLE, char_valid=0, char_idx=0, char_out=0, bcd=0, colon phase visible.
REQ-031 Reset mid-frame aborts the frame; dirty=1 after reset release so the first frame shows RESET_TIME.

Configuration
REQ-032 Macro TIMER_COLON_BLINK_EN: defined -> while running, colon phase toggles each tick_1hz; idx2 emits 8'h3A when visible and 8'h20 when hidden; each toggle sets dirty.
REQ-033 Without TIMER_COLON_BLINK_EN: idx2 always 8'h3A; no colon-driven frames.

Verification
REQ-034 Reset release, char_ready=1 -> frame "05:00" (8'h30,8'h35,8'h3A,8'h30,8'h30), idx 0..4, char_valid low after.
REQ-035 load 16'h1000, start, one tick -> time_bcd=16'h0959, frame "09:59".
REQ-036 load 16'h0001, start, tick -> time_bcd=0000, expired=1, running=0; later ticks leave 0000.
REQ-037 char_ready low 3 cycles at idx1, tick during stall -> idx1 char held stable; current frame completes unchanged, second frame shows new time.
REQ-038 load and tick same cycle with load_bcd=16'hFA99 -> time_bcd=16'h9599, running=0, tick dropped.
REQ-039 rst asserted at idx3 -> char_valid=0 immediately; after release frame restarts at idx0 with RESET_TIME.
